// File: rtl/regfile_pkg.sv
// Shared constants and the write-port arbitration helper for the multi-port register file.
package regfile_pkg;

    localparam int DATA_W_DEF = 32;
    localparam int ADDR_W_DEF = 5;
    localparam int ZERO_ADDR  = 0;
    localparam int MAX_WR     = 8;

    // Highest-index asserted bit wins; -1 means no port targets the address.
    function automatic int win_port(input logic [MAX_WR-1:0] hit);
        int w;
        w = -1;
        for (int k = 0; k < MAX_WR; k++) begin
            if (hit[k]) begin
                w = k;
            end
        end
        return w;
    endfunction

endpackage

// File: rtl/regfile_mp_if.sv
// Read/write/scoreboard bus between the pipeline and the register file.
interface regfile_mp_if
    import regfile_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int NUM_RD = 2,
    parameter int NUM_WR = 1
);

    logic [NUM_RD*ADDR_W-1:0] ra;
    logic [NUM_RD*DATA_W-1:0] rd;
    logic [NUM_RD-1:0]        rbusy;
    logic [NUM_WR-1:0]        we;
    logic [NUM_WR*ADDR_W-1:0] wa;
    logic [NUM_WR*DATA_W-1:0] wd;
    logic                     bset;
    logic [ADDR_W-1:0]        bset_addr;
    logic                     flush;

    modport master (
        output ra, we, wa, wd, bset, bset_addr, flush,
        input  rd, rbusy
    );

    modport slave (
        input  ra, we, wa, wd, bset, bset_addr, flush,
        output rd, rbusy
    );

endinterface

// File: rtl/regfile_scoreboard.sv
// Per-register pending-write bits: set by issue, cleared by writeback or flush.
module regfile_scoreboard
    import regfile_pkg::*;
#(
    parameter int ADDR_W   = ADDR_W_DEF,
    parameter int NUM_RD   = 2,
    parameter int NUM_WR   = 1,
    parameter int ZERO_REG = 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NUM_WR-1:0]        we_i,
    input  logic [NUM_WR*ADDR_W-1:0] wa_i,
    input  logic                     bset_i,
    input  logic [ADDR_W-1:0]        bset_addr_i,
    input  logic                     flush_i,
    input  logic [NUM_RD*ADDR_W-1:0] ra_i,
    input  logic [NUM_RD-1:0]        byp_hit_i,
    output logic [NUM_RD-1:0]        rbusy_o
);

    localparam int DEPTH = 2**ADDR_W;

    logic [DEPTH-1:0] busy_q;
    logic [DEPTH-1:0] busy_d;

    // A set always beats a clear or flush on the same edge: it is a newer producer.
    always_comb begin
        busy_d = busy_q;
        for (int a = 0; a < DEPTH; a++) begin
            logic clr;
            clr = flush_i;
            for (int k = 0; k < NUM_WR; k++) begin
                if (we_i[k] && (wa_i[k*ADDR_W +: ADDR_W] == ADDR_W'(a))) begin
                    clr = 1'b1;
                end
            end
            if (bset_i && (bset_addr_i == ADDR_W'(a))) begin
                busy_d[a] = 1'b1;
            end else if (clr) begin
                busy_d[a] = 1'b0;
            end
        end
        if (ZERO_REG != 0) begin
            busy_d[ZERO_ADDR] = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            busy_q <= '0;
        end else begin
            busy_q <= busy_d;
        end
    end

    generate
        for (genvar gi = 0; gi < NUM_RD; gi++) begin : g_rbusy
            assign rbusy_o[gi] = busy_q[ra_i[gi*ADDR_W +: ADDR_W]] & ~byp_hit_i[gi];
        end
    endgenerate

endmodule

// File: rtl/regfile_mp.sv
// Parametrised multi-port register file with same-cycle bypass and hazard scoreboard.
module regfile_mp
    import regfile_pkg::*;
#(
    parameter int DATA_W   = DATA_W_DEF,
    parameter int ADDR_W   = ADDR_W_DEF,
    parameter int NUM_RD   = 2,
    parameter int NUM_WR   = 1,
    parameter int ZERO_REG = 1,
    parameter int BYPASS   = 1
) (
    input  logic        clk,
    input  logic        rst,
    regfile_mp_if.slave bus
);

    localparam int DEPTH = 2**ADDR_W;

    logic [DATA_W-1:0] mem [DEPTH];
    logic [NUM_WR-1:0] we_act;
    logic [NUM_RD-1:0] byp_hit;

    // Writes are inert while reset is held, so nothing is forwarded either.
    assign we_act = bus.we & {NUM_WR{rst}};

    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_reg
            if ((ZERO_REG != 0) && (gi == ZERO_ADDR)) begin : g_zero
                assign mem[gi] = '0;
            end else begin : g_store
                logic [MAX_WR-1:0] hit;
                int                win;
                logic [DATA_W-1:0] val_q;

                always_comb begin
                    hit = '0;
                    for (int k = 0; k < NUM_WR; k++) begin
                        hit[k] = we_act[k] && (bus.wa[k*ADDR_W +: ADDR_W] == ADDR_W'(gi));
                    end
                    win = win_port(hit);
                end

                always_ff @(posedge clk or negedge rst) begin
                    if (!rst) begin
                        val_q <= '0;
                    end else if (win >= 0) begin
                        val_q <= bus.wd[win*DATA_W +: DATA_W];
                    end
                end

                assign mem[gi] = val_q;
            end
        end

        for (genvar gi = 0; gi < NUM_RD; gi++) begin : g_rd
            logic [ADDR_W-1:0] addr;
            logic              is_zero;
            logic [MAX_WR-1:0] hit;
            int                win;
            logic [DATA_W-1:0] rd_val;

            always_comb begin
                addr    = bus.ra[gi*ADDR_W +: ADDR_W];
                is_zero = (ZERO_REG != 0) && (addr == ADDR_W'(ZERO_ADDR));
                hit     = '0;
                for (int k = 0; k < NUM_WR; k++) begin
                    if (BYPASS != 0) begin
                        hit[k] = we_act[k] && (bus.wa[k*ADDR_W +: ADDR_W] == addr);
                    end
                end
                win = win_port(hit);
                if (is_zero) begin
                    rd_val = '0;
                end else if (win >= 0) begin
                    rd_val = bus.wd[win*DATA_W +: DATA_W];
                end else begin
                    rd_val = mem[addr];
                end
            end

            assign byp_hit[gi]                   = (win >= 0) && !is_zero;
            assign bus.rd[gi*DATA_W +: DATA_W]   = rd_val;
        end
    endgenerate

    regfile_scoreboard #(
        .ADDR_W   (ADDR_W),
        .NUM_RD   (NUM_RD),
        .NUM_WR   (NUM_WR),
        .ZERO_REG (ZERO_REG)
    ) u_scoreboard (
        .clk         (clk),
        .rst         (rst),
        .we_i        (we_act),
        .wa_i        (bus.wa),
        .bset_i      (bus.bset),
        .bset_addr_i (bus.bset_addr),
        .flush_i     (bus.flush),
        .ra_i        (bus.ra),
        .byp_hit_i   (byp_hit),
        .rbusy_o     (bus.rbusy)
    );

endmodule

// File: tb/tb_regfile_mp.sv
// Directed bench: dual-write bypassing file (u_a) alongside a single-write non-bypassing file (u_b).
module tb_regfile_mp;

    logic clk;
    logic rst;
    int   errors;
    int   checks;

    regfile_mp_if #(.DATA_W(32), .ADDR_W(5), .NUM_RD(2), .NUM_WR(2)) if_a ();
    regfile_mp_if #(.DATA_W(32), .ADDR_W(5), .NUM_RD(2), .NUM_WR(1)) if_b ();

    regfile_mp #(
        .DATA_W(32), .ADDR_W(5), .NUM_RD(2), .NUM_WR(2), .ZERO_REG(1), .BYPASS(1)
    ) u_a (
        .clk (clk),
        .rst (rst),
        .bus (if_a)
    );

    regfile_mp #(
        .DATA_W(32), .ADDR_W(5), .NUM_RD(2), .NUM_WR(1), .ZERO_REG(1), .BYPASS(0)
    ) u_b (
        .clk (clk),
        .rst (rst),
        .bus (if_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
        $display("check %-14s observed=%h expected=%h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_rd(input logic [4:0] a0, input logic [4:0] a1);
        if_a.ra = {a1, a0};
        if_b.ra = {a1, a0};
    endtask

    task automatic wr_a(input logic [1:0] we, input logic [4:0] wa0, input logic [4:0] wa1,
                        input logic [31:0] wd0, input logic [31:0] wd1);
        if_a.we = we;
        if_a.wa = {wa1, wa0};
        if_a.wd = {wd1, wd0};
    endtask

    task automatic wr_b(input logic we, input logic [4:0] wa, input logic [31:0] wd);
        if_b.we = we;
        if_b.wa = wa;
        if_b.wd = wd;
    endtask

    task automatic bset_both(input logic en, input logic [4:0] addr, input logic fl);
        if_a.bset = en; if_a.bset_addr = addr; if_a.flush = fl;
        if_b.bset = en; if_b.bset_addr = addr; if_b.flush = fl;
    endtask

    task automatic idle();
        wr_a(2'b00, 5'd0, 5'd0, 32'h0, 32'h0);
        wr_b(1'b0, 5'd0, 32'h0);
        bset_both(1'b0, 5'd0, 1'b0);
    endtask

    initial begin
        errors = 0;
        checks = 0;
        rst    = 1'b0;
        idle();
        set_rd(5'd0, 5'd1);

        // Reset held for two edges
        repeat (2) @(posedge clk);
        #1;
        chk("rst_rd_a",   if_a.rd[31:0],  32'h0);
        chk("rst_busy_a", {30'h0, if_a.rbusy}, 32'h0);
        rst = 1'b1;

        for (int a = 0; a < 32; a++) begin
            set_rd(a[4:0], 5'(31 - a));
            #1;
            chk("all_rd_a",  if_a.rd[31:0] | if_a.rd[63:32], 32'h0);
            chk("all_rd_b",  if_b.rd[31:0] | if_b.rd[63:32], 32'h0);
            chk("all_busy",  {30'h0, if_a.rbusy | if_b.rbusy}, 32'h0);
        end

        // Writes to register 0 are dropped and never forwarded
        tick();
        set_rd(5'd0, 5'd0);
        wr_a(2'b11, 5'd0, 5'd0, 32'hDEADBEEF, 32'hDEADBEEF);
        wr_b(1'b1, 5'd0, 32'hDEADBEEF);
        #2;
        chk("r0_byp_a", if_a.rd[31:0], 32'h0);
        tick();
        idle();
        #2;
        chk("r0_after_a", if_a.rd[31:0], 32'h0);
        chk("r0_after_b", if_b.rd[31:0], 32'h0);

        // Same-cycle bypass versus old value
        tick();
        set_rd(5'd5, 5'd0);
        wr_a(2'b01, 5'd5, 5'd0, 32'h12345678, 32'h0);
        wr_b(1'b1, 5'd5, 32'h12345678);
        #2;
        chk("byp_r5_a", if_a.rd[31:0], 32'h12345678);
        chk("old_r5_b", if_b.rd[31:0], 32'h0);
        tick();
        idle();
        #2;
        chk("r5_a", if_a.rd[31:0], 32'h12345678);
        chk("r5_b", if_b.rd[31:0], 32'h12345678);

        // Dual-write conflict: port 1 wins
        tick();
        set_rd(5'd7, 5'd5);
        wr_a(2'b11, 5'd7, 5'd7, 32'hAAAA0000, 32'h5555FFFF);
        #2;
        chk("dual_byp", if_a.rd[31:0], 32'h5555FFFF);
        tick();
        idle();
        #2;
        chk("dual_r7", if_a.rd[31:0], 32'h5555FFFF);
        chk("dual_r5", if_a.rd[63:32], 32'h12345678);

        // Two independent writes in one cycle
        tick();
        set_rd(5'd8, 5'd12);
        wr_a(2'b11, 5'd8, 5'd12, 32'h11111111, 32'h22222222);
        #2;
        chk("pair_byp0", if_a.rd[31:0],  32'h11111111);
        chk("pair_byp1", if_a.rd[63:32], 32'h22222222);
        tick();
        idle();
        #2;
        chk("pair_r8",  if_a.rd[31:0],  32'h11111111);
        chk("pair_r12", if_a.rd[63:32], 32'h22222222);

        // Scoreboard set
        tick();
        set_rd(5'd9, 5'd0);
        bset_both(1'b1, 5'd9, 1'b0);
        #2;
        chk("bset_same_a", {31'h0, if_a.rbusy[0]}, 32'h0);
        tick();
        idle();
        #2;
        chk("busy9_a", {31'h0, if_a.rbusy[0]}, 32'h1);
        chk("busy9_b", {31'h0, if_b.rbusy[0]}, 32'h1);
        chk("busy0_a", {31'h0, if_a.rbusy[1]}, 32'h0);

        // Writeback clears; bypass hides busy in the write cycle
        tick();
        wr_a(2'b01, 5'd9, 5'd0, 32'h00000099, 32'h0);
        wr_b(1'b1, 5'd9, 32'h00000099);
        #2;
        chk("wb9_byp_a", {31'h0, if_a.rbusy[0]}, 32'h0);
        chk("wb9_nob_b", {31'h0, if_b.rbusy[0]}, 32'h1);
        tick();
        idle();
        #2;
        chk("wb9_clr_a", {31'h0, if_a.rbusy[0]}, 32'h0);
        chk("wb9_clr_b", {31'h0, if_b.rbusy[0]}, 32'h0);

        // Same-edge set and clear: set wins
        tick();
        wr_a(2'b10, 5'd0, 5'd9, 32'h0, 32'h00000AAA);
        wr_b(1'b1, 5'd9, 32'h00000AAA);
        bset_both(1'b1, 5'd9, 1'b0);
        #2;
        chk("setclr_ca", {31'h0, if_a.rbusy[0]}, 32'h0);
        chk("setclr_cb", {31'h0, if_b.rbusy[0]}, 32'h0);
        tick();
        idle();
        #2;
        chk("setclr_a",  {31'h0, if_a.rbusy[0]}, 32'h1);
        chk("setclr_b",  {31'h0, if_b.rbusy[0]}, 32'h1);
        chk("setclr_rd", if_a.rd[31:0], 32'h00000AAA);

        // Flush with a same-cycle set
        tick();
        bset_both(1'b1, 5'd3, 1'b0);
        tick();
        bset_both(1'b1, 5'd4, 1'b0);
        tick();
        bset_both(1'b1, 5'd10, 1'b0);
        tick();
        idle();
        set_rd(5'd3, 5'd10);
        #2;
        chk("pre_fl_a", {30'h0, if_a.rbusy}, 32'h3);
        bset_both(1'b1, 5'd4, 1'b1);
        tick();
        idle();
        set_rd(5'd3, 5'd4);
        #2;
        chk("fl_r3_r4_a", {30'h0, if_a.rbusy}, 32'h2);
        chk("fl_r3_r4_b", {30'h0, if_b.rbusy}, 32'h2);
        set_rd(5'd10, 5'd9);
        #1;
        chk("fl_r10_r9",  {30'h0, if_a.rbusy}, 32'h0);

        // Asynchronous reset between edges with a write pending
        tick();
        set_rd(5'd5, 5'd20);
        wr_a(2'b01, 5'd20, 5'd0, 32'hCAFEF00D, 32'h0);
        wr_b(1'b1, 5'd20, 32'hCAFEF00D);
        bset_both(1'b1, 5'd21, 1'b0);
        #1;
        chk("pre_rst_byp", if_a.rd[63:32], 32'hCAFEF00D);
        rst = 1'b0;
        #1;
        chk("arst_r5_a",  if_a.rd[31:0],  32'h0);
        chk("arst_r5_b",  if_b.rd[31:0],  32'h0);
        chk("arst_r20_a", if_a.rd[63:32], 32'h0);
        tick();
        idle();
        rst = 1'b1;
        set_rd(5'd20, 5'd4);
        #2;
        chk("rel_r20_a",  if_a.rd[31:0], 32'h0);
        chk("rel_r20_b",  if_b.rd[31:0], 32'h0);
        chk("rel_busy_a", {30'h0, if_a.rbusy}, 32'h0);
        set_rd(5'd21, 5'd9);
        #1;
        chk("rel_busy21", {30'h0, if_a.rbusy | if_b.rbusy}, 32'h0);

        // Normal operation resumes
        tick();
        set_rd(5'd0, 5'd20);
        wr_a(2'b01, 5'd20, 5'd0, 32'h0BADCAFE, 32'h0);
        wr_b(1'b1, 5'd20, 32'h0BADCAFE);
        tick();
        idle();
        #2;
        chk("post_r20_a", if_a.rd[63:32], 32'h0BADCAFE);
        chk("post_r20_b", if_b.rd[63:32], 32'h0BADCAFE);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/regfile_mp.md
Name: regfile_mp

Overview:
- Parametrised multi-port register file for the pipelined MIPS core. Successor to the fixed 32x32, 2-read/1-write file.
- Generalised in width, depth, read-port count and write-port count.
- Adds same-cycle write-to-read bypass and a per-register pending-write scoreboard. Decode uses the scoreboard for hazard stalls; the WB stage(s) write through this block.

Parameters:
- DATA_W, 32, register width in bits
- ADDR_W, 5, address width; depth = 2**ADDR_W
- NUM_RD, 2, number of read ports
- NUM_WR, 1, number of write ports (2 for dual-retire configurations)
- ZERO_REG, 1, 1 = register 0 reads 0 and ignores writes and busy-sets
- BYPASS, 1, 1 = same-cycle write data forwarded to read outputs

Ports:
- clk  in  1  clock, all state updates on rising edge
- rst  in  1  asynchronous, active-low reset
- ra  in  NUM_RD*ADDR_W  read addresses; port j = bits [j*ADDR_W +: ADDR_W]
- rd  out  NUM_RD*DATA_W  read data, same packing
- rbusy  out  NUM_RD  pending-write flag for each read address
- we  in  NUM_WR  write enables
- wa  in  NUM_WR*ADDR_W  write addresses
- wd  in  NUM_WR*DATA_W  write data
- bset  in  1  mark register bset_addr as pending (issued producer)
- bset_addr  in  ADDR_W  register to mark
- flush  in  1  synchronously clear all busy bits

Behaviour:
- Reset:
  - rst=0 asynchronously clears every register and every busy bit to 0.
  - While rst=0: rd = 0 and rbusy = 0; we, bset and flush are ignored.
  - Reset mid-operation discards any in-flight write.
- Write:
  - At the rising edge, for each k with we[k]=1: reg[wa[k]] <= wd[k].
  - With ZERO_REG=1, writes to address 0 are dropped.
  - Same address on multiple ports in one cycle: the highest-index port wins.
  - Write latency is 1 cycle: the array value is visible from the next cycle.
- Read:
  - Reads are combinational, with no clock latency.
  - ZERO_REG=1 and ra_j=0 -> rd_j = 0 and rbusy_j = 0, irrespective of writes.
  - BYPASS=1: if any active write port targets ra_j in the current cycle, rd_j = wd of the highest-index matching port; otherwise rd_j = reg[ra_j].
  - BYPASS=0: rd_j = reg[ra_j] (old value during the write cycle).
- Scoreboard:
  - One busy bit per register.
  - Set: bset=1 sets busy[bset_addr] at the edge. Ignored for address 0 when ZERO_REG=1.
  - Clear: an active write to address a clears busy[a] at the edge.
  - Same-edge set and clear on the same address: set wins (a newer producer has issued).
  - flush=1 clears all busy bits at the edge. A bset in the same cycle is applied after the flush, so its bit ends at 1.
  - rbusy_j = busy[ra_j], except with BYPASS=1 when a same-cycle active write targets ra_j, in which case rbusy_j = 0 (data forwarded).
- Widths: no arithmetic. Address compare is full ADDR_W. Out-of-range addresses are impossible because depth = 2**ADDR_W.
- Concurrency: all NUM_RD reads and NUM_WR writes operate independently in the same cycle.

Decomposition:
- Shared package regfile_pkg holds:
  - default DATA_W / ADDR_W constants
  - the ZERO_ADDR constant
  - a function computing the winning write port index for a given address (used by both the write path and the bypass path)
- One sub-module, regfile_scoreboard (busy bits, set/clear/flush priority, rbusy lookup). Instantiated inside regfile_mp; the storage array and bypass mux stay in the top.

Test Plan:
- Reset/zero: rst=0 for 2 cycles, release; read all 32 addresses -> every rd = 0 and rbusy = 0. Write 0xDEADBEEF to reg 0 -> reg 0 still reads 0.
- Write/read and bypass: with BYPASS=1, write r5=0x12345678 with ra0=5 in the same cycle -> rd0 = 0x12345678 that cycle. With BYPASS=0 -> rd0 = old value 0 that cycle and 0x12345678 the next.
- Dual-write conflict: NUM_WR=2, we=2'b11, wa0=wa1=7, wd0=0xAAAA0000, wd1=0x5555FFFF -> r7 = 0x5555FFFF; bypassed rd also 0x5555FFFF.
- Scoreboard: bset r9 -> next cycle rbusy=1 for ra=9. Write r9 -> rbusy=0 in the write cycle (bypass) and after. Same-edge bset r9 plus write r9 -> busy stays 1.
- Flush: set busy on r3, r4, r10, then flush=1 with bset r4 in the same cycle -> only r4 busy afterwards.
- Async reset mid-operation: assert rst low between edges while we=1 -> registers and busy bits read 0 immediately, no write lands; release -> normal operation from the next edge.
